// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM encoding and block geometry for the direct-mapped instruction cache.
package icache_pkg;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MEM_READ = 2'd1;
    localparam logic [1:0] UPDATE   = 2'd2;
    localparam int BLOCK_BYTES      = 16;
    localparam int WORDS_PER_BLOCK  = 4;
    localparam int OFFSET_W         = 4;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage with combinational read and synchronous write.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IW        = 3,
    parameter int TAG_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IW-1:0]            rd_index,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [BLOCK_BYTES*8-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_index,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [BLOCK_BYTES*8-1:0] wr_data
);
    logic [NUM_LINES-1:0]     valid;
    logic [TAG_W-1:0]         tags [NUM_LINES];
    logic [BLOCK_BYTES*8-1:0] data [NUM_LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= '0;
        else if (wr_en)
            valid[wr_index] <= 1'b1;
    end

    // Tag and data need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with a 16-byte block refill FSM.
// Define ICACHE_PERF_EN to add saturating hit_count/miss_count outputs.
module icache_direct
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int ADDR_W    = 10
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                PC,
    output logic [31:0]                INSTRUCTION,
    output logic                       BUSYWAIT,
    output logic                       mem_read,
    output logic [ADDR_W-OFFSET_W-1:0] mem_address,
    input  logic [127:0]               mem_readdata,
    input  logic                       mem_busywait
`ifdef ICACHE_PERF_EN
    ,
    output logic [15:0]                hit_count,
    output logic [15:0]                miss_count
`endif
);
    localparam int IW    = $clog2(NUM_LINES);
    localparam int BW    = ADDR_W - OFFSET_W;
    localparam int TAG_W = BW - IW;

    logic [1:0]       state;
    logic [BW-1:0]    blk_q;
    logic [127:0]     fill_q;
    logic [31:0]      instr_q;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [127:0]     rd_data;
    logic [BW-1:0]    pc_blk;
    logic [31:0]      word;
    logic             hit;
    logic             idle_hit;
    logic             unused_pc;

    assign pc_blk    = PC[ADDR_W-1:OFFSET_W];
    assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};
    assign word      = rd_data[{PC[3:2], 5'd0} +: 32];
    assign hit       = rd_valid && rd_tag == pc_blk[BW-1:IW];
    assign idle_hit  = state == IDLE && hit;

    assign BUSYWAIT    = !idle_hit;
    assign INSTRUCTION = idle_hit ? word : instr_q;
    assign mem_read    = state == MEM_READ;
    assign mem_address = blk_q;

    icache_line_array #(.NUM_LINES(NUM_LINES), .IW(IW), .TAG_W(TAG_W)) u_lines (
        .clk      (CLK),
        .rst_n    (RESET),
        .rd_index (pc_blk[IW-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (state == UPDATE),
        .wr_index (blk_q[IW-1:0]),
        .wr_tag   (blk_q[BW-1:IW]),
        .wr_data  (fill_q)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            blk_q   <= '0;
            instr_q <= '0;
        end else begin
            if (idle_hit)
                instr_q <= word;
            if (state == IDLE && !hit)
                blk_q <= pc_blk;
            state <= state == IDLE     ? (hit ? IDLE : MEM_READ) :
                     state == MEM_READ ? (mem_busywait ? MEM_READ : UPDATE) : IDLE;
        end
    end

    // A reset mid-refill leaves the FSM in IDLE, so stale fill data is never written.
    always_ff @(posedge CLK) begin
        if (mem_read && !mem_busywait)
            fill_q <= mem_readdata;
    end

`ifdef ICACHE_PERF_EN
    logic        first_q;
    logic [31:0] last_pc;

    // last_pc also tracks missing PCs so the post-refill hit is not counted twice.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
            first_q    <= 1'b1;
            last_pc    <= '0;
        end else if (state == IDLE) begin
            first_q <= 1'b0;
            last_pc <= PC;
            if (hit && (first_q || PC != last_pc) && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (!hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed plus randomized checks of icache_direct against a block-residency model.
module tb_icache_direct;
    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [31:0]  PC = 32'h0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_PERF_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int n_assert = 0;
    int n_fail = 0;
    int lat = 2;
    int cnt = 0;

    int          res [8];
    logic [31:0] last_instr;
    logic [31:0] prev_pc;
    bit          first;
    int          exp_hits;
    int          exp_misses;

    icache_direct dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory: each word holds its own byte address; data valid on the lat-th read cycle.
    function automatic logic [127:0] blk_data(logic [5:0] b);
        logic [127:0] d;
        for (int w = 0; w < 4; w++) begin
            logic [1:0] wv;
            wv = w[1:0];
            d[w*32 +: 32] = {22'b0, b, wv, 2'b00};
        end
        return d;
    endfunction

    always @(posedge CLK) cnt <= mem_read ? cnt + 1 : 0;
    assign mem_busywait = !(mem_read && cnt >= lat - 1);
    assign mem_readdata = mem_read ? blk_data(mem_address) : {4{32'hDEADBEEF}};

    function automatic logic [31:0] exp_word(logic [31:0] pc);
        return pc & 32'h0000_03FC;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) res[i] = -1;
        last_instr = 32'h0;
        prev_pc    = 32'h0;
        first      = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic reset_checks();
        chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
        chk("rst_mem_addr", {26'b0, mem_address}, 32'h0);
        chk("rst_instr", INSTRUCTION, 32'h0);
        chk("rst_busywait", {31'b0, BUSYWAIT}, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        reset_checks();
        model_reset();
    endtask

    // One fetch: drive PC (releasing any pending reset), then follow hit or full refill.
    task automatic access(input logic [31:0] pc, input int l);
        int  blk, idx, busy, rd;
        bit  h;
        logic last_rd;
        blk = int'(pc[9:4]);
        idx = blk & 7;
        h = res[idx] == blk;
        busy = 0;
        rd = 0;
        last_rd = 1'b0;
        @(negedge CLK);
        PC = pc;
        lat = l;
        RESET = 1'b1;
        #1;
        chk("busywait", {31'b0, BUSYWAIT}, {31'b0, !h});
        if (h) begin
            chk("hit_instr", INSTRUCTION, exp_word(pc));
            chk("hit_no_read", {31'b0, mem_read}, 32'h0);
        end else begin
            while (BUSYWAIT && busy < 200) begin
                busy++;
                chk("hold_instr", INSTRUCTION, last_instr);
                if (mem_read) begin
                    rd++;
                    chk("mem_addr", {26'b0, mem_address}, blk);
                end
                last_rd = mem_read;
                @(negedge CLK);
                #1;
            end
            chk("miss_cycles", busy, l + 2);
            chk("read_cycles", rd, l);
            chk("update_no_read", {31'b0, last_rd}, 32'h0);
            chk("refill_instr", INSTRUCTION, exp_word(pc));
            res[idx] = blk;
            exp_misses++;
        end
        if (h && (first || pc != prev_pc)) exp_hits++;
        first = 1'b0;
        prev_pc = pc;
        last_instr = exp_word(pc);
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  b;
        logic [1:0]  w;
        model_reset();
        #1;
        reset_checks();
        access(32'h000, 2);
        access(32'h004, 1);
        access(32'h008, 1);
        access(32'h00C, 1);
        access(32'h080, 5);
        access(32'h000, 3);
        access(32'h3FC, 2);
        access(32'h000, 1);
        access(32'hABCDE3FC, 1);
        access(32'h004, 1);
        // Abort a refill with reset, then the previously cached PC=4 must miss.
        @(negedge CLK);
        PC = 32'h040;
        lat = 5;
        @(negedge CLK);
        #1;
        chk("midfill_read", {31'b0, mem_read}, 32'h1);
        #2;
        RESET = 1'b0;
        #1;
        chk("abort_read", {31'b0, mem_read}, 32'h0);
        chk("abort_busy", {31'b0, BUSYWAIT}, 32'h1);
        model_reset();
        access(32'h004, 3);
        do_reset();
        access(32'h000, 2);
        access(32'h004, 1);
        access(32'h008, 1);
        access(32'h080, 4);
        access(32'h000, 1);
`ifdef ICACHE_PERF_EN
        chk("perf_hits", {16'b0, hit_count}, 32'd2);
        chk("perf_misses", {16'b0, miss_count}, 32'd3);
`endif
        for (int i = 0; i < 80; i++) begin
            r = $urandom();
            b = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 11));
            w = 2'($urandom_range(0, 3));
            access({r[31:10], b, w, 2'b00}, $urandom_range(1, 6));
        end
`ifdef ICACHE_PERF_EN
        chk("final_hits", {16'b0, hit_count}, exp_hits);
        chk("final_misses", {16'b0, miss_count}, exp_misses);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
